// File: rtl/test_fifo_pkg.sv
// Shared sizing, LED bit map and operation decode for the FIFO demo board block.
package test_fifo_pkg;

  localparam int DATA_WIDTH = 3;
  localparam int ADDR_WIDTH = 2;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam int LED_FULL     = 7;
  localparam int LED_EMPTY    = 6;
  localparam int LED_ERR      = 5;
  localparam int LED_FRUTA_HI = 4;
  localparam int LED_FRUTA_LO = 3;
  localparam int LED_DATA_HI  = 2;
  localparam int LED_DATA_LO  = 0;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic wr_tick, input logic rd_tick);
    return op_e'({rd_tick, wr_tick});
  endfunction

endpackage

// File: rtl/test_fifo_edge_tick.sv
// Rising-edge pulse generator: one single-cycle tick per low-to-high transition of in.
module edge_tick (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic tick
);

  logic in_q;

  // Clearing in_q on reset lets a button held through reset still produce one tick.
  always_ff @(posedge clk) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign tick = in & ~in_q;

endmodule

// File: rtl/test_fifo.sv
// Push-button driven 4-entry FIFO; LEDs show head word, occupancy, flags and sticky error.
module test_fifo
  import test_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] sw,
  output logic [7:0]            led
);

  logic wr_tick;
  logic rd_tick;

  edge_tick u_wr_tick (
    .clk   (clk),
    .reset (reset),
    .in    (wr),
    .tick  (wr_tick)
  );

  edge_tick u_rd_tick (
    .clk   (clk),
    .reset (reset),
    .in    (rd),
    .tick  (rd_tick)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  error;

  op_e                   op;
  logic                  do_wr;
  logic                  do_rd;
  logic                  err_nxt;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [DATA_WIDTH-1:0] salida;

  assign op = decode_op(wr_tick, rd_tick);

  // A simultaneous pair on an empty FIFO degrades to a plain write.
  always_comb begin
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    err_nxt = error;
    unique case (op)
      OP_WR: begin
        if (full) err_nxt = 1'b1;
        else begin
          do_wr   = 1'b1;
          err_nxt = 1'b0;
        end
      end
      OP_RD: begin
        if (empty) err_nxt = 1'b1;
        else begin
          do_rd   = 1'b1;
          err_nxt = 1'b0;
        end
      end
      OP_BOTH: begin
        do_wr   = 1'b1;
        do_rd   = ~empty;
        err_nxt = 1'b0;
      end
      default: ;
    endcase

    count_nxt = count;
    if (do_wr && !do_rd)      count_nxt = count + 1'b1;
    else if (do_rd && !do_wr) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      error  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (ADDR_WIDTH+1)'(DEPTH));
      empty <= (count_nxt == '0);
      error <= err_nxt;
    end
  end

  // Storage carries no reset; only the pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wr_ptr] <= sw;
  end

  assign salida = empty ? '0 : mem[rd_ptr];

  always_comb begin
    led                            = '0;
    led[LED_FULL]                  = full;
    led[LED_EMPTY]                 = empty;
    led[LED_ERR]                   = error;
    led[LED_FRUTA_HI:LED_FRUTA_LO] = count[ADDR_WIDTH-1:0];
    led[LED_DATA_HI:LED_DATA_LO]   = salida;
  end

endmodule

// File: tb/tb_test_fifo.sv
// Scoreboard bench for test_fifo: stimulus queues expected LED words, a monitor compares them.
module tb_test_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [2:0] sw;
  logic [7:0] led;

  int cyc     = 0;
  int n_check = 0;
  int n_pass  = 0;

  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sbq[$];

  test_fifo dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (rd),
    .sw    (sw),
    .led   (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each queued expectation is due at the negedge of the cycle it names.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      n_check++;
      if (e.cyc != cyc)
        $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
      else if (led !== e.exp)
        $display("FAIL %s: cycle %0d led=%b expected=%b", e.name, cyc, led, e.exp);
      else
        n_pass++;
    end
  end

  // Hold the given inputs for n cycles; led must equal exp after each of those edges.
  task automatic step(input logic w, input logic r, input logic [2:0] s, input logic rs,
                      input int n, input logic [7:0] exp, input string name);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      wr    = w;
      rd    = r;
      sw    = s;
      reset = rs;
      e.cyc  = cyc + 1;
      e.exp  = exp;
      e.name = name;
      sbq.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, led=%b", led);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    sw    = 3'b000;
    @(posedge clk);
    #1;

    // led = {full, empty, error, fruta[1:0], salida[2:0]}
    step(0, 0, 3'b000, 1, 2, 8'b0_1_0_00_000, "reset");
    step(0, 0, 3'b000, 0, 5, 8'b0_1_0_00_000, "idle_after_reset");

    step(1, 0, 3'b011, 0, 5, 8'b0_0_0_01_011, "hold_wr_3");
    step(0, 0, 3'b011, 0, 1, 8'b0_0_0_01_011, "release_wr");
    step(1, 0, 3'b010, 0, 3, 8'b0_0_0_10_011, "hold_wr_2");
    step(0, 0, 3'b010, 0, 1, 8'b0_0_0_10_011, "release_wr2");

    step(0, 1, 3'b001, 0, 1, 8'b0_0_0_01_010, "pop_sw001");
    step(0, 1, 3'b101, 0, 1, 8'b0_0_0_01_010, "pop_hold_sw101");
    step(0, 1, 3'b111, 0, 1, 8'b0_0_0_01_010, "pop_hold_sw111");
    step(0, 0, 3'b111, 0, 1, 8'b0_0_0_01_010, "release_rd");

    step(1, 0, 3'b100, 0, 1, 8'b0_0_0_10_010, "push_4");
    step(0, 0, 3'b100, 0, 1, 8'b0_0_0_10_010, "gap_4");
    step(1, 0, 3'b101, 0, 1, 8'b0_0_0_11_010, "push_5");
    step(0, 0, 3'b101, 0, 1, 8'b0_0_0_11_010, "gap_5");
    step(1, 0, 3'b110, 0, 1, 8'b1_0_0_00_010, "push_6_full");
    step(0, 0, 3'b110, 0, 1, 8'b1_0_0_00_010, "gap_6");
    step(1, 0, 3'b111, 0, 1, 8'b1_0_1_00_010, "push_when_full");
    step(0, 0, 3'b111, 0, 2, 8'b1_0_1_00_010, "error_sticky");

    step(0, 1, 3'b000, 0, 1, 8'b0_0_0_11_100, "pop_clears_error");
    step(0, 0, 3'b000, 0, 1, 8'b0_0_0_11_100, "gap_p1");
    step(0, 1, 3'b000, 0, 1, 8'b0_0_0_10_101, "pop_head5");
    step(0, 0, 3'b000, 0, 1, 8'b0_0_0_10_101, "gap_p2");
    step(0, 1, 3'b000, 0, 1, 8'b0_0_0_01_110, "pop_head6_wrap");
    step(0, 0, 3'b000, 0, 1, 8'b0_0_0_01_110, "gap_p3");
    step(0, 1, 3'b000, 0, 1, 8'b0_1_0_00_000, "pop_to_empty");
    step(0, 0, 3'b000, 0, 1, 8'b0_1_0_00_000, "gap_p4");

    step(0, 1, 3'b000, 0, 1, 8'b0_1_1_00_000, "pop_when_empty");
    step(0, 0, 3'b000, 0, 1, 8'b0_1_1_00_000, "gap_err");

    step(1, 1, 3'b101, 0, 1, 8'b0_0_0_01_101, "both_on_empty");
    step(0, 0, 3'b101, 0, 1, 8'b0_0_0_01_101, "gap_both1");
    step(1, 1, 3'b011, 0, 1, 8'b0_0_0_01_011, "both_nonempty");
    step(0, 0, 3'b011, 0, 1, 8'b0_0_0_01_011, "gap_both2");

    step(1, 0, 3'b110, 1, 2, 8'b0_1_0_00_000, "reset_with_wr");
    step(1, 0, 3'b110, 0, 3, 8'b0_0_0_01_110, "wr_after_reset");
    step(0, 0, 3'b110, 0, 1, 8'b0_0_0_01_110, "final_idle");

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_check++;
      $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
